// File: rtl/gcd_pkg.sv
// Shared types and datapath select encodings for the GCD control/datapath pair.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SELA_LOAD = 2'b00;
    localparam logic [1:0] SELA_SWAP = 2'b01;
    localparam logic [1:0] SELA_SUB  = 2'b10;

    localparam logic [1:0] SELB_LOAD = 2'b00;
    localparam logic [1:0] SELB_SWAP = 2'b01;
    localparam logic [1:0] SELB_HOLD = 2'b11;

endpackage

// File: rtl/gcd_datapath.sv
// GCD datapath: A/B registers steered by selA/selB, plus the result register
// which captures A whenever B is held at zero.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned WL = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [WL-1:0] op_a,
    input  logic [WL-1:0] op_b,
    input  logic [1:0]    selA,
    input  logic [1:0]    selB,
    output logic [WL-1:0] curr_A,
    output logic [WL-1:0] curr_B,
    output logic [WL-1:0] res
);

    logic [WL-1:0] a_q, a_d;
    logic [WL-1:0] b_q, b_d;
    logic [WL-1:0] res_q, res_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        case (selA)
            SELA_LOAD: a_d = op_a;
            SELA_SWAP: a_d = b_q;
            SELA_SUB:  a_d = a_q - b_q;
            default:   a_d = a_q;
        endcase
        case (selB)
            SELB_LOAD: b_d = op_b;
            SELB_SWAP: b_d = a_q;
            SELB_HOLD: b_d = b_q;
            default:   b_d = b_q;
        endcase
        // Holding B at zero only happens on the terminating step and in DONE
        if (selB == SELB_HOLD && b_q == '0) begin
            res_d = a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
        end
    end

    assign curr_A = a_q;
    assign curr_B = b_q;
    assign res    = res_q;

endmodule

// File: rtl/gcd_top.sv
// GCD block: control FSM wired to its datapath.
module gcd_top
    import gcd_pkg::*;
#(
    parameter int unsigned WL = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [WL-1:0] op_a,
    input  logic [WL-1:0] op_b,
    output logic [WL-1:0] res,
    output logic          busy,
    output logic [CW-1:0] cycles
);

    logic [WL-1:0] curr_a;
    logic [WL-1:0] curr_b;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;

    gcd_control #(.WL(WL), .CW(CW)) u_ctrl (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .curr_A    (curr_a),
        .curr_B    (curr_b),
        .selA      (sel_a),
        .selB      (sel_b),
        .busy      (busy),
        .cycles    (cycles)
    );

    gcd_datapath #(.WL(WL)) u_dp (
        .clk    (clk),
        .rst_b  (rst_b),
        .op_a   (op_a),
        .op_b   (op_b),
        .selA   (sel_a),
        .selB   (sel_b),
        .curr_A (curr_a),
        .curr_B (curr_b),
        .res    (res)
    );

endmodule

// File: rtl/gcd_control.sv
// Control FSM for the subtract/swap GCD datapath: operand handshake, select
// generation from curr_A/curr_B feedback, result handshake and cycle count.
module gcd_control
    import gcd_pkg::*;
#(
    parameter int unsigned WL = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic [WL-1:0] curr_A,
    input  logic [WL-1:0] curr_B,
    output logic [1:0]    selA,
    output logic [1:0]    selB,
    output logic          busy,
    output logic [CW-1:0] cycles
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [CW-1:0] cnt_inc;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          b_zero;
    logic          a_lt_b;

    assign b_zero  = (curr_B == '0);
    assign a_lt_b  = (curr_A < curr_B);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // Next state, counter and status flags decoded from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_inc;
                if (b_zero) begin
                    state_d  = DONE;
                    cycles_d = cnt_inc;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CALC);
    end

    // Selects must track the live feedback, so they decode state_q directly
    always_comb begin
        selA = SELA_LOAD;
        selB = SELB_LOAD;
        case (state_q)
            IDLE: begin
                selA = SELA_LOAD;
                selB = SELB_LOAD;
            end
            CALC: begin
                if (!b_zero && a_lt_b) begin
                    selA = SELA_SWAP;
                    selB = SELB_SWAP;
                end else begin
                    selA = SELA_SUB;
                    selB = SELB_HOLD;
                end
            end
            DONE: begin
                selA = SELA_SUB;
                selB = SELB_HOLD;
            end
            default: begin
                selA = SELA_LOAD;
                selB = SELB_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cycles_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycles_q    <= cycles_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_control.sv
// Bench for gcd_control driving the GCD datapath; results scored against a
// reference GCD/step-count model.
module tb_gcd_control;
    import gcd_pkg::*;

    localparam int unsigned WL = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [WL-1:0] op_a = '0;
    logic [WL-1:0] op_b = '0;
    logic          in_ready, out_valid, busy;
    logic [WL-1:0] curr_A, curr_B, res;
    logic [1:0]    selA, selB;
    logic [CW-1:0] cycles;

    typedef struct packed {
        logic [WL-1:0] res;
        logic [CW-1:0] cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    gcd_control #(.WL(WL), .CW(CW)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .curr_A    (curr_A),
        .curr_B    (curr_B),
        .selA      (selA),
        .selB      (selB),
        .busy      (busy),
        .cycles    (cycles)
    );

    gcd_datapath #(.WL(WL)) u_dp (
        .clk    (clk),
        .rst_b  (rst_b),
        .op_a   (op_a),
        .op_b   (op_b),
        .selA   (selA),
        .selB   (selB),
        .curr_A (curr_A),
        .curr_B (curr_B),
        .res    (res)
    );

    // Reference: Euclid by subtraction, one step per loop pass, final pass sees B==0
    function automatic exp_t model(input logic [WL-1:0] a, input logic [WL-1:0] b);
        logic [WL-1:0] x;
        logic [WL-1:0] y;
        logic [WL-1:0] t;
        int            c;
        exp_t          e;
        x = a;
        y = b;
        c = 0;
        for (int i = 0; i < 100000; i++) begin
            c++;
            if (y == '0) break;
            if (x < y) begin
                t = x;
                x = y;
                y = t;
            end else begin
                x = x - y;
            end
        end
        e.res = x;
        e.cyc = (c > 65535) ? '1 : CW'(c);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_b) begin
            n_checks++;
            if (selA === 2'b11) begin
                n_fail++;
                $display("FAIL selA_illegal: selA=%b (must never be 11) at %0t", selA, $time);
            end
            if (in_valid && in_ready) sb.push_back(model(op_a, op_b));
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: result res=%0d with nothing expected", res);
                end else begin
                    mon_e = sb.pop_front();
                    if (res !== mon_e.res) begin
                        n_fail++;
                        $display("FAIL sb_res: got %0d expected %0d", res, mon_e.res);
                    end
                    n_checks++;
                    if (cycles !== mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL sb_cycles: got %0d expected %0d", cycles, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [WL-1:0] a, input logic [WL-1:0] b);
        int n;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b expected 1 within 400 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (!out_valid && lat < budget) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL done_timeout: out_valid=%b expected 1 within %0d cycles", out_valid, budget);
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1 rst_b = 1'b0;
        #2;
        n_checks += 6;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (selA !== SELA_LOAD) begin n_fail++; $display("FAIL rst_selA: got %b expected 00", selA); end
        if (selB !== SELB_LOAD) begin n_fail++; $display("FAIL rst_selB: got %b expected 00", selB); end
        if (cycles !== '0) begin n_fail++; $display("FAIL rst_cycles: got %0d expected 0", cycles); end
        repeat (2) @(posedge clk);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [1:0] exp_a [6];
        logic [1:0] exp_b [6];
        logic [1:0] got_a [6];
        logic [1:0] got_b [6];
        int idx;
        exp_a = '{SELA_SUB, SELA_SWAP, SELA_SUB, SELA_SUB, SELA_SWAP, SELA_SUB};
        exp_b = '{SELB_HOLD, SELB_SWAP, SELB_HOLD, SELB_HOLD, SELB_SWAP, SELB_HOLD};
        out_ready = 1'b1;
        send(8'd12, 8'd8);
        idx = 0;
        while (!out_valid && idx < 300) begin
            if (idx < 6) begin
                got_a[idx] = selA;
                got_b[idx] = selB;
            end
            @(posedge clk);
            #1;
            idx++;
        end
        n_checks++;
        if (idx != 6) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid after %0d edges expected 6", idx);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks += 2;
            if (got_a[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL basic_selA[%0d]: got %b expected %b", i, got_a[i], exp_a[i]);
            end
            if (got_b[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL basic_selB[%0d]: got %b expected %b", i, got_b[i], exp_b[i]);
            end
        end
        n_checks += 2;
        if (res !== 8'd4) begin n_fail++; $display("FAIL basic_res: got %0d expected 4", res); end
        if (cycles !== 16'd6) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 6", cycles); end
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle: in_ready=%b expected 1", in_ready); end
    endtask

    task automatic test_zero();
        int lat;
        send(8'd7, 8'd0);
        wait_done(50, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        send(8'd0, 8'd0);
        wait_done(50, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL zerozero_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_worst();
        int lat;
        out_ready = 1'b0;
        send(8'd1, 8'd255);
        wait_done(400, lat);
        n_checks += 3;
        if (lat != 258) begin n_fail++; $display("FAIL worst_latency: got %0d expected 258", lat); end
        if (cycles !== 16'd258) begin n_fail++; $display("FAIL worst_cycles: got %0d expected 258", cycles); end
        if (res !== 8'd1) begin n_fail++; $display("FAIL worst_res: got %0d expected 1", res); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(8'd48, 8'd18);
        wait_done(300, lat);
        for (int i = 0; i < 10; i++) begin
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
            if (res !== 8'd6) begin n_fail++; $display("FAIL bp_res[%0d]: got %0d expected 6", i, res); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            in_valid = i[0];
            op_a     = 8'd100;
            op_b     = 8'd50;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL bp_ignored_input: %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_reset_abort();
        int lat;
        send(8'd200, 8'd3);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        #2 rst_b = 1'b0;
        #1;
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (cycles !== '0) begin n_fail++; $display("FAIL abort_cycles: got %0d expected 0", cycles); end
        if (selA !== SELA_LOAD) begin n_fail++; $display("FAIL abort_selA: got %b expected 00", selA); end
        sb.delete();
        @(posedge clk);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;
        send(8'd9, 8'd6);
        wait_done(50, lat);
        n_checks++;
        if (lat != 6) begin n_fail++; $display("FAIL abort_after_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            send(WL'($urandom_range(0, 255)), WL'($urandom_range(0, 255)));
        end
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d results outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_worst();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
